// File: rtl/frequency_meter_if.sv
// Frequency meter port bundle.
// Carries the measurement control and result signals between the meter and
// its consumer (the 7-segment counter datapath).
//   enable     : consumer -> meter, high = measure continuously
//   sig_in     : external asynchronous signal under measurement
//   freq_hz    : meter -> consumer, edge count of the last completed window
//   meas_valid : meter -> consumer, one-cycle pulse when freq_hz updates
//   overflow   : meter -> consumer, last completed window saturated
//   busy       : meter -> consumer, high while a gate window is running
interface frequency_meter_if #(
  parameter int unsigned CNT_W = 27
);
  logic             enable;
  logic             sig_in;
  logic [CNT_W-1:0] freq_hz;
  logic             meas_valid;
  logic             overflow;
  logic             busy;

  // Meter side
  modport slave (
    input  enable,
    input  sig_in,
    output freq_hz,
    output meas_valid,
    output overflow,
    output busy
  );

  // Consumer side
  modport master (
    output enable,
    output sig_in,
    input  freq_hz,
    input  meas_valid,
    input  overflow,
    input  busy
  );
endinterface

// File: rtl/frequency_meter.sv
// Frequency meter.
// Counts synchronized rising edges of sig_in over back-to-back gate windows
// of GATE_CYCLES clk_100MHz cycles and publishes the saturated count on
// freq_hz with a one-cycle meas_valid pulse. Dropping enable aborts the
// current window without publishing.
//   clk_100MHz : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   meas       : frequency_meter_if slave modport (enable, sig_in in;
//                freq_hz, meas_valid, overflow, busy out)
module frequency_meter #(
  parameter int unsigned GATE_CYCLES = 100000000,
  parameter int unsigned CNT_W       = 27
) (
  input  logic              clk_100MHz,
  input  logic              rst_n,
  frequency_meter_if.slave  meas
);

  // The gate counter is never narrower than needed for GATE_CYCLES-1, so a
  // narrow CNT_W only limits the reported count, not the window length.
  localparam int unsigned GATE_W = (CNT_W > $clog2(GATE_CYCLES)) ? CNT_W
                                                                 : $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [GATE_W-1:0] GATE_ONE  = GATE_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic {
    ST_IDLE,
    ST_GATE
  } state_e;

  state_e            state_q, state_d;
  logic              s1_q, s1_d;
  logic              s2_q, s2_d;
  logic              s3_q, s3_d;
  logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic              sat_q, sat_d;
  logic [CNT_W-1:0]  freq_q, freq_d;
  logic              overflow_q, overflow_d;
  logic              meas_valid_q, meas_valid_d;
  logic              rise;

  assign rise = s2_q & ~s3_q;

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      gate_cnt_q   <= '0;
      edge_cnt_q   <= '0;
      sat_q        <= 1'b0;
      freq_q       <= '0;
      overflow_q   <= 1'b0;
      meas_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      gate_cnt_q   <= gate_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      sat_q        <= sat_d;
      freq_q       <= freq_d;
      overflow_q   <= overflow_d;
      meas_valid_q <= meas_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    gate_cnt_d   = gate_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    sat_d        = sat_q;
    freq_d       = freq_q;
    overflow_d   = overflow_q;
    meas_valid_d = 1'b0;
    // Synchronizer runs in every state
    s1_d         = meas.sig_in;
    s2_d         = s1_q;
    s3_d         = s2_q;

    case (state_q)
      ST_IDLE: begin
        if (meas.enable) begin
          state_d    = ST_GATE;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
        end
      end
      ST_GATE: begin
        if (!meas.enable) begin
          // Abort: window discarded, published result holds
          state_d = ST_IDLE;
        end else if (gate_cnt_q != GATE_LAST) begin
          gate_cnt_d = gate_cnt_q + GATE_ONE;
          if (rise) begin
            if (edge_cnt_q == CNT_MAX) begin
              sat_d = 1'b1;
            end else begin
              edge_cnt_d = edge_cnt_q + CNT_ONE;
            end
          end
        end else begin
          // Terminal cycle: a rise here still belongs to the closing window;
          // the next window starts on the following cycle with no gap.
          if (rise && (edge_cnt_q == CNT_MAX)) begin
            freq_d     = CNT_MAX;
            overflow_d = 1'b1;
          end else begin
            freq_d     = edge_cnt_q + (rise ? CNT_ONE : '0);
            overflow_d = sat_q;
          end
          meas_valid_d = 1'b1;
          gate_cnt_d   = '0;
          edge_cnt_d   = '0;
          sat_d        = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign meas.freq_hz    = freq_q;
  assign meas.meas_valid = meas_valid_q;
  assign meas.overflow   = overflow_q;
  assign meas.busy       = (state_q == ST_GATE);

endmodule

// File: tb/tb_frequency_meter.sv
module tb_frequency_meter;

  localparam int G    = 100;
  localparam int W_M  = 7;
  localparam int W_S  = 4;
  localparam int MAXM = (1 << W_M) - 1;
  localparam int MAXS = (1 << W_S) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_r = 1'b0;
  logic sig_r = 1'b0;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  frequency_meter_if #(.CNT_W(W_M)) bus_m ();
  frequency_meter_if #(.CNT_W(W_S)) bus_s ();

  assign bus_m.enable = en_r;
  assign bus_m.sig_in = sig_r;
  assign bus_s.enable = en_r;
  assign bus_s.sig_in = sig_r;

  frequency_meter #(.GATE_CYCLES(G), .CNT_W(W_M)) dut_m (
    .clk_100MHz (clk),
    .rst_n      (rst_n),
    .meas       (bus_m.slave)
  );

  frequency_meter #(.GATE_CYCLES(G), .CNT_W(W_S)) dut_s (
    .clk_100MHz (clk),
    .rst_n      (rst_n),
    .meas       (bus_s.slave)
  );

  // Reference model: sampled-input history plus window bookkeeping by edge index
  int hist [0:8191];
  int m = 0;
  bit active = 1'b0;
  int k = 0;
  int exp_freq_m = 0, exp_freq_s = 0;
  int exp_ov_m = 0, exp_ov_s = 0;
  int exp_mv = 0, exp_busy = 0;
  int ph = 0;

  // A rise is counted at the edge two edges after sig_in is first sampled high
  function automatic int rise_at(input int e);
    int cur, prev;
    cur  = (e >= 2) ? hist[e-2] : 0;
    prev = (e >= 3) ? hist[e-3] : 0;
    return (cur == 1 && prev == 0) ? 1 : 0;
  endfunction

  task automatic model_edge();
    int cnt;
    hist[m] = int'(sig_r);
    exp_mv = 0;
    if (!active) begin
      if (en_r) begin
        active = 1'b1;
        k = m;
      end
    end else if (!en_r) begin
      active = 1'b0;
    end else if (((m - k) % G) == 0) begin
      cnt = 0;
      for (int e = m - G + 1; e <= m; e++) cnt += rise_at(e);
      exp_freq_m = (cnt > MAXM) ? MAXM : cnt;
      exp_ov_m   = (cnt > MAXM) ? 1 : 0;
      exp_freq_s = (cnt > MAXS) ? MAXS : cnt;
      exp_ov_s   = (cnt > MAXS) ? 1 : 0;
      exp_mv = 1;
    end
    exp_busy = active ? 1 : 0;
    m++;
  endtask

  task automatic model_reset();
    m = 0;
    active = 1'b0;
    exp_freq_m = 0; exp_freq_s = 0;
    exp_ov_m = 0; exp_ov_s = 0;
    exp_mv = 0; exp_busy = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_all();
    chk("m_busy",   32'(bus_m.busy),       32'(exp_busy));
    chk("m_mv",     32'(bus_m.meas_valid), 32'(exp_mv));
    chk("m_freq",   32'(bus_m.freq_hz),    32'(exp_freq_m));
    chk("m_ovf",    32'(bus_m.overflow),   32'(exp_ov_m));
    chk("s_busy",   32'(bus_s.busy),       32'(exp_busy));
    chk("s_mv",     32'(bus_s.meas_valid), 32'(exp_mv));
    chk("s_freq",   32'(bus_s.freq_hz),    32'(exp_freq_s));
    chk("s_ovf",    32'(bus_s.overflow),   32'(exp_ov_s));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_m_freq"}, 32'(bus_m.freq_hz), 0);
    chk({tag, "_m_mv"},   32'(bus_m.meas_valid), 0);
    chk({tag, "_m_ovf"},  32'(bus_m.overflow), 0);
    chk({tag, "_m_busy"}, 32'(bus_m.busy), 0);
    chk({tag, "_s_freq"}, 32'(bus_s.freq_hz), 0);
    chk({tag, "_s_busy"}, 32'(bus_s.busy), 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // hi=0 holds low, lo=0 holds high, otherwise a hi/lo square wave
  task automatic run_cycles(input int n, input int hi, input int lo);
    ph = ph % (hi + lo);
    for (int i = 0; i < n; i++) begin
      sig_r = (ph < hi);
      ph = (ph + 1) % (hi + lo);
      tick();
    end
  endtask

  task automatic wait_publish(input int hi, input int lo);
    int n = 0;
    ph = ph % (hi + lo);
    do begin
      sig_r = (ph < hi);
      ph = (ph + 1) % (hi + lo);
      tick();
      n++;
    end while (exp_mv == 0 && n < 3 * G);
    chk("publish_seen", 32'(exp_mv), 1);
  endtask

  initial begin
    int saved;
    int hi, lo;

    // Power-on reset
    #3;
    chk_zero("por");
    #19 rst_n = 1'b1;
    model_reset();

    // Idle with toggling input: rises ignored
    en_r = 1'b0;
    run_cycles(7, 5, 5);

    // Nominal: period 10, first pulse 100 edges after enable is sampled
    en_r = 1'b1;
    run_cycles(1, 5, 5);
    run_cycles(99, 5, 5);
    chk("first_pulse_early", 32'(bus_m.meas_valid), 0);
    run_cycles(1, 5, 5);
    chk("first_pulse_mv", 32'(bus_m.meas_valid), 1);
    chk("first_pulse_freq", 32'(bus_m.freq_hz), 10);
    run_cycles(250, 5, 5);

    // DC low for several windows
    run_cycles(300, 0, 1);
    chk("dc_low_freq", 32'(bus_m.freq_hz), 0);
    wait_publish(0, 1);

    // Terminal-cycle rise: counted in the closing window only
    for (int i = 1; i <= 200; i++) begin
      sig_r = (i >= 98 && i <= 110);
      tick();
      if (i == 100) begin
        chk("term_mv", 32'(bus_m.meas_valid), 1);
        chk("term_freq", 32'(bus_m.freq_hz), 1);
      end
      if (i == 200) begin
        chk("term_next_mv", 32'(bus_m.meas_valid), 1);
        chk("term_next_freq", 32'(bus_m.freq_hz), 0);
      end
    end

    // DC high
    run_cycles(300, 1, 0);
    chk("dc_high_freq", 32'(bus_m.freq_hz), 0);

    // Maximum rate: 25 edges, saturates the narrow instance
    run_cycles(300, 2, 2);
    chk("sat_m_freq", 32'(bus_m.freq_hz), 25);
    chk("sat_s_freq", 32'(bus_s.freq_hz), 15);
    chk("sat_s_ovf", 32'(bus_s.overflow), 1);
    run_cycles(300, 10, 10);
    chk("slow_s_freq", 32'(bus_s.freq_hz), 5);
    chk("slow_s_ovf", 32'(bus_s.overflow), 0);

    // Abort at gate cycle 50, then restart
    wait_publish(3, 4);
    run_cycles(50, 3, 4);
    saved = exp_freq_m;
    en_r = 1'b0;
    run_cycles(1, 3, 4);
    chk("abort_busy", 32'(bus_m.busy), 0);
    chk("abort_hold", 32'(bus_m.freq_hz), 32'(saved));
    run_cycles(20, 3, 4);
    en_r = 1'b1;
    run_cycles(100, 3, 4);
    chk("restart_early", 32'(bus_m.meas_valid), 0);
    run_cycles(1, 3, 4);
    chk("restart_mv", 32'(bus_m.meas_valid), 1);

    // Randomized segments with occasional aborts
    for (int seg = 0; seg < 8; seg++) begin
      hi = $urandom_range(2, 12);
      lo = $urandom_range(2, 12);
      run_cycles($urandom_range(50, 250), hi, lo);
      if ($urandom_range(0, 3) == 0) begin
        en_r = 1'b0;
        run_cycles($urandom_range(1, 10), hi, lo);
        en_r = 1'b1;
      end
    end

    // Asynchronous reset mid-window
    run_cycles(130, 4, 3);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    en_r = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    run_cycles(3, 4, 3);
    chk("post_rst_idle", 32'(bus_m.busy), 0);
    en_r = 1'b1;
    for (int seg = 0; seg < 3; seg++) begin
      run_cycles($urandom_range(100, 200), $urandom_range(2, 9), $urandom_range(2, 9));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
